// File: rtl/regfile_wr_demux_pkg.sv
// Shared constants and types for the register file slice.
// Default geometry: 8 registers of 16 bits, addressed by a 3-bit select.
package regfile_wr_demux_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_NREGS = 8;
  localparam int RF_ASEL  = 3;

  typedef logic [RF_ASEL-1:0]  rf_sel_t;
  typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/regfile_wr_demux_reg_en.sv
// One register-file entry: a WIDTH-bit register with write enable, plus a
// sticky flag recording that the entry has been written since reset.
module reg_en #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en_i) begin
      data_d  = d_i;
      valid_d = 1'b1;
    end
  end

  // Reset wins over a write arriving on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/regfile_wr_demux.sv
// Register file: one decoded write port fanning writeData to a single entry,
// two combinational read ports with optional same-cycle write bypass.
module regfile_wr_demux
  import regfile_wr_demux_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int NREGS  = RF_NREGS,
  parameter int ASEL   = RF_ASEL,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASEL-1:0]  writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             write,
  input  logic [ASEL-1:0]  read1RegSel,
  input  logic [ASEL-1:0]  read2RegSel,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic [NREGS-1:0] wrValid
);

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             byp1, byp2;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign wr_en[i] = write && (writeRegSel == ASEL'(i));

    reg_en #(.WIDTH(WIDTH)) u_reg (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (wr_en[i]),
      .d_i     (writeData),
      .q_o     (regs_q[i]),
      .valid_o (wrValid[i])
    );
  end

  // Bypass is purely combinational, so it is visible even while rst is held.
  assign byp1 = (BYPASS != 0) && write && (read1RegSel == writeRegSel);
  assign byp2 = (BYPASS != 0) && write && (read2RegSel == writeRegSel);

  assign read1Data = byp1 ? writeData : regs_q[read1RegSel];
  assign read2Data = byp2 ? writeData : regs_q[read2RegSel];

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Bench for regfile_wr_demux: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array-based reference model.
module tb_regfile_wr_demux;
  import regfile_wr_demux_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  rf_sel_t  writeRegSel = '0;
  rf_word_t writeData = '0;
  logic     write = 1'b0;
  rf_sel_t  read1RegSel = '0;
  rf_sel_t  read2RegSel = '0;
  rf_word_t read1Data, read2Data, nb_read1Data, nb_read2Data;
  logic [RF_NREGS-1:0] wrValid, nb_wrValid;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  rf_word_t            mdl_mem [RF_NREGS];
  logic [RF_NREGS-1:0] mdl_valid;

  always #5 clk = ~clk;

  regfile_wr_demux #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .writeRegSel(writeRegSel), .writeData(writeData),
    .write(write), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(read1Data), .read2Data(read2Data), .wrValid(wrValid)
  );

  regfile_wr_demux #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .writeRegSel(writeRegSel), .writeData(writeData),
    .write(write), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(nb_read1Data), .read2Data(nb_read2Data), .wrValid(nb_wrValid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rf_word_t exp_read(input rf_sel_t sel, input bit bypass);
    if (bypass && write && sel == writeRegSel) return writeData;
    return mdl_mem[sel];
  endfunction

  // Apply one cycle of inputs, optionally check outputs just before the
  // rising edge, then advance the model across that edge.
  task automatic step(input bit do_chk, input logic r, input logic w,
                      input rf_sel_t ws, input rf_word_t wd,
                      input rf_sel_t r1, input rf_sel_t r2);
    @(negedge clk);
    rst = r; write = w; writeRegSel = ws; writeData = wd;
    read1RegSel = r1; read2RegSel = r2;
    #1;
    if (do_chk) begin
      chk("rd1_byp",   32'(read1Data),    32'(exp_read(r1, 1'b1)));
      chk("rd2_byp",   32'(read2Data),    32'(exp_read(r2, 1'b1)));
      chk("rd1_nobyp", 32'(nb_read1Data), 32'(exp_read(r1, 1'b0)));
      chk("rd2_nobyp", 32'(nb_read2Data), 32'(exp_read(r2, 1'b0)));
      chk("wrvalid",    32'(wrValid),    32'(mdl_valid));
      chk("wrvalid_nb", 32'(nb_wrValid), 32'(mdl_valid));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < RF_NREGS; i++) mdl_mem[i] = '0;
      mdl_valid = '0;
    end else if (w) begin
      mdl_mem[ws] = wd;
      mdl_valid[ws] = 1'b1;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < RF_NREGS; i += 2)
      step(1, 0, 0, rf_sel_t'($urandom_range(0, 7)), rf_word_t'($urandom),
           rf_sel_t'(i), rf_sel_t'(i + 1));
  endtask

  initial begin
    for (int i = 0; i < RF_NREGS; i++) mdl_mem[i] = 'x;
    mdl_valid = 'x;

    // initial reset; contents are unknown beforehand
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);

    // reset clears everything
    for (int i = 0; i < RF_NREGS; i++) step(1, 0, 1, rf_sel_t'(i), 16'hFFFF, 0, 7);
    read_all();
    step(1, 1, 0, 0, 0, 1, 2);
    read_all();
    chk("reset_clears_valid", 32'(wrValid), 32'h00);

    // write then read
    step(1, 0, 1, 3, 16'hBEEF, 0, 1);
    step(1, 0, 0, 0, 0, 3, 4);
    chk("wr_then_rd", 32'(read1Data), 32'hBEEF);
    chk("wr_then_rd_valid", 32'(wrValid), 32'h08);

    // same-cycle bypass on both ports
    step(1, 0, 1, 5, 16'h1234, 5, 5);
    step(1, 0, 0, 0, 0, 5, 5);

    // demux isolation
    for (int i = 0; i < RF_NREGS; i++) step(1, 0, 1, rf_sel_t'(i), rf_word_t'(i + 1), 7, 0);
    read_all();
    chk("all_valid", 32'(wrValid), 32'hFF);

    // reset priority over a same-edge write
    step(1, 1, 1, 2, 16'hAAAA, 2, 3);
    step(1, 0, 1, 2, 16'hAAAA, 2, 2);
    step(1, 0, 0, 0, 0, 2, 3);
    chk("post_reset_write", 32'(read1Data), 32'hAAAA);

    // last write wins
    step(1, 0, 1, 7, 16'h1111, 7, 6);
    step(1, 0, 1, 7, 16'h2222, 7, 7);
    step(1, 0, 0, 0, 0, 7, 6);
    chk("last_write_wins", 32'(read1Data), 32'h2222);

    // unchanged data still sets wrValid
    step(1, 0, 1, 6, 16'h0000, 6, 6);
    step(1, 0, 0, 0, 0, 6, 5);

    // random traffic with occasional resets
    for (int n = 0; n < 300; n++)
      step(1, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           rf_sel_t'($urandom_range(0, 7)), rf_word_t'($urandom),
           rf_sel_t'($urandom_range(0, 7)), rf_sel_t'($urandom_range(0, 7)));
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_demux.md
Name: regfile_wr_demux

Overview:
- Processor register file whose write port is the demultiplexing end of the read-side select muxes.
- One write port decodes writeRegSel into per-register write enables and fans writeData out to the selected register.
- Two read ports select register contents back out; an optional same-cycle bypass is provided.
- Sits between the writeback stage and decode in the unpipelined processor datapath.

Parameters:
- WIDTH, 16, data width of each register in bits.
- NREGS, 8, number of registers; must be a power of two.
- ASEL, 3, select width; must equal log2(NREGS).
- BYPASS, 1, 1 = read ports return writeData when the write address matches the read address in the same cycle; 0 = read ports return stored contents only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- writeRegSel  input  ASEL  destination register index.
- writeData  input  WIDTH  data to store.
- write  input  1  write strobe; high = commit writeData on this edge.
- read1RegSel  input  ASEL  read port 1 index.
- read2RegSel  input  ASEL  read port 2 index.
- read1Data  output  WIDTH  read port 1 data.
- read2Data  output  WIDTH  read port 2 data.
- wrValid  output  NREGS  bit i = 1 once register i has been written since reset.

Behaviour:
- Clocking: one clock domain (clk). Reset rst is synchronous and active-high and is sampled only on the rising clk edge.
- Reset: on a rising edge with rst=1, all registers become 0 and wrValid becomes 0.
  - rst has priority over a simultaneous write; that write is discarded.
  - While rst is held, read1Data and read2Data show stored zeros. With BYPASS=1 they still bypass writeData when write=1 and the addresses match (combinational path), but nothing is stored.
- Write demux: enable[i] = write AND (writeRegSel == i), so exactly one enable is active when write=1 and none when write=0.
  - On a rising edge with enable[i]=1: reg[i] <= writeData and wrValid[i] <= 1.
  - All other registers hold their value.
  - Write latency: 1 cycle; the stored value is visible via stored contents from the next cycle.
- Read: combinational from the select inputs.
  - BYPASS=1: readNData = writeData when write=1 and readNRegSel == writeRegSel; otherwise reg[readNRegSel].
  - BYPASS=0: readNData = reg[readNRegSel] always.
  - Both read ports are independent. Both may select the same register, and both may match the write address simultaneously; each then returns writeData.
- Register 0 is an ordinary writable register (no hardwired zero).
- Back-to-back writes to the same index on consecutive edges: the last write wins; no stall.
- write=1 with writeData unchanged still sets wrValid.
- wrValid bits are sticky until reset.
- Reset mid-operation: a write pending on the reset edge is lost; the next edge after rst deasserts accepts writes normally.
- Width rule: no truncation or extension; writeData and readNData are exactly WIDTH bits.

Decomposition:
- Shared package holds:
  - constants RF_WIDTH=16, RF_NREGS=8, RF_ASEL=3;
  - typedef rf_sel_t (ASEL bits);
  - typedef rf_word_t (WIDTH bits).
- One natural sub-module, reg_en: a WIDTH-bit register with synchronous active-high reset and write enable.
  - Instantiated NREGS times, one per decoded enable.
  - Also holds that register's wrValid bit.
- The write decoder and read select muxes are written inline in the parent.

Test Plan:
- Reset clears: write 0xFFFF into every register, assert rst for 1 cycle -> all reads return 0x0000 and wrValid=8'h00.
- Write then read: write=1, writeRegSel=3, writeData=0xBEEF; next cycle write=0, read1RegSel=3, read2RegSel=4 -> read1Data=0xBEEF, read2Data=0x0000, wrValid=8'h08.
- Bypass (BYPASS=1): write=1, writeRegSel=5, writeData=0x1234, read1RegSel=5, read2RegSel=5 in the same cycle -> both reads 0x1234 before the edge. Repeat with BYPASS=0 -> both reads show the old reg[5].
- Demux isolation: write 0x0001 through 0x0008 into registers 0-7 on consecutive cycles, then read all pairs -> each register holds only its own value and wrValid=8'hFF.
- Reset priority: rst=1 and write=1, writeRegSel=2, writeData=0xAAAA on the same edge -> reg[2]=0x0000 and wrValid[2]=0. The next cycle's write of 0xAAAA -> read returns 0xAAAA.
- Last write wins: writes of 0x1111 then 0x2222 to register 7 on consecutive edges -> read returns 0x2222 and wrValid[7]=1.
